// File: rtl/frame_draw_ctrl_if.sv
// Signals between the frame draw controller, the frame ROMs, the game FSM and the VGA adapter.
// master = frame_draw_ctrl, slave = the surrounding system.
interface frame_draw_ctrl_if;
  logic [2:0]  iState;
  logic [2:0]  iColour;
  logic [14:0] oAddress;
  logic [2:0]  oFrameSel;
  logic [7:0]  oX;
  logic [6:0]  oY;
  logic [2:0]  oColour;
  logic        oPlot;
  logic        oBusy;
  logic        oFrameDone;

  modport master (
    input  iState, iColour,
    output oAddress, oFrameSel, oX, oY, oColour, oPlot, oBusy, oFrameDone
  );

  modport slave (
    output iState, iColour,
    input  oAddress, oFrameSel, oX, oY, oColour, oPlot, oBusy, oFrameDone
  );
endinterface

// File: rtl/frame_draw_ctrl.sv
// Redraws a full 160x120 frame from the ROM selected by the game state whenever that state changes.
// ROM read and output register give a fixed two-cycle address-to-plot pipeline.
module frame_draw_ctrl (
  input  logic              iClock,
  input  logic              iResetn,
  frame_draw_ctrl_if.master bus
);
  // state | meaning
  // IDLE  | frame on screen is current, waiting for a redraw request
  // FETCH | presenting one ROM address per cycle, 0..19199
  // DRAIN | two cycles flushing the pixel pipeline
  // DONE  | one-cycle frame-complete pulse
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  localparam logic [14:0] LAST_ADDR = 15'd19199;
  localparam logic [7:0]  LAST_X    = 8'd159;
  localparam logic [2:0]  BLANK_SEL = 3'd7;

  state_t      state;
  logic        pending;
  logic [2:0]  prev_state;
  logic [14:0] addr;
  logic [7:0]  x;
  logic [6:0]  y;
  logic        drain_cnt;
  logic        p1_valid;
  logic [7:0]  p1_x;
  logic [6:0]  p1_y;
  logic        redraw;

  // A change seen this very cycle counts as pending, so a change during DONE chains straight into FETCH.
  assign redraw = pending || (bus.iState != prev_state);

  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      state          <= IDLE;
      pending        <= 1'b1;
      prev_state     <= bus.iState;
      addr           <= '0;
      x              <= '0;
      y              <= '0;
      drain_cnt      <= 1'b0;
      p1_valid       <= 1'b0;
      p1_x           <= '0;
      p1_y           <= '0;
      bus.oAddress   <= '0;
      bus.oFrameSel  <= '0;
      bus.oX         <= '0;
      bus.oY         <= '0;
      bus.oColour    <= '0;
      bus.oPlot      <= 1'b0;
      bus.oBusy      <= 1'b0;
      bus.oFrameDone <= 1'b0;
    end else begin
      prev_state <= bus.iState;
      p1_valid   <= 1'b0;
      bus.oPlot  <= p1_valid;
      if (p1_valid) begin
        bus.oX      <= p1_x;
        bus.oY      <= p1_y;
        bus.oColour <= (bus.oFrameSel == BLANK_SEL) ? 3'd0 : bus.iColour;
      end

      case (state)
        IDLE, DONE: begin
          bus.oFrameDone <= 1'b0;
          pending        <= 1'b0;
          if (redraw) begin
            state         <= FETCH;
            bus.oFrameSel <= bus.iState;
            bus.oAddress  <= '0;
            bus.oBusy     <= 1'b1;
            addr          <= '0;
            x             <= '0;
            y             <= '0;
          end else begin
            state <= IDLE;
          end
        end

        FETCH: begin
          pending  <= redraw;
          p1_valid <= 1'b1;
          p1_x     <= x;
          p1_y     <= y;
          if (addr == LAST_ADDR) begin
            addr      <= '0;
            x         <= '0;
            y         <= '0;
            drain_cnt <= 1'b1;
            state     <= DRAIN;
          end else begin
            addr         <= addr + 15'd1;
            bus.oAddress <= addr + 15'd1;
            if (x == LAST_X) begin
              x <= '0;
              y <= y + 7'd1;
            end else begin
              x <= x + 8'd1;
            end
          end
        end

        DRAIN: begin
          pending <= redraw;
          if (drain_cnt == 1'b0) begin
            state          <= DONE;
            bus.oBusy      <= 1'b0;
            bus.oFrameDone <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/frame_draw_ctrl.md
FRAME_DRAW_CTRL -- requirements
Module: frame_draw_ctrl

Interface
REQ-001 SHALL expose iClock, input, 1, sole clock; all logic on its rising edge.
REQ-002 SHALL expose iResetn, input, 1, synchronous active-low reset, sampled on rising iClock.
REQ-003 SHALL expose iState, input, 3, game state: 0 Start, 1 Game, 2 Mole1, 3 Mole2, 4 Mole3, 5 Mole4, 6 GameOver, 7 invalid.
REQ-004 SHALL expose iColour, input, 3, ROM pixel data, valid the cycle after oAddress/oFrameSel are presented.
REQ-005 SHALL expose oAddress, output, 15, registered ROM read address, row-major: y*160+x.
REQ-006 SHALL expose oFrameSel, output, 3, registered frame-ROM select, equal to the latched state; external mux routes the selected ROM q to iColour.
REQ-007 SHALL expose oX, output, 8, registered pixel x (0..159).
REQ-008 SHALL expose oY, output, 7, registered pixel y (0..119).
REQ-009 SHALL expose oColour, output, 3, registered pixel colour.
REQ-010 SHALL expose oPlot, output, 1, VGA adapter write strobe; high only for a valid pixel.
REQ-011 SHALL expose oBusy, output, 1, high while a frame draw is in progress (FETCH/DRAIN).
REQ-012 SHALL expose oFrameDone, output, 1, one-cycle pulse after the last pixel of a frame is plotted.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, DRAIN, DONE.
REQ-014 SHALL hold a pending flag; set by reset release and by any cycle where iState differs from the registered previous iState.
REQ-015 IDLE with pending=1 SHALL go to FETCH next cycle, clearing pending and latching iState into oFrameSel on that edge.
REQ-016 FETCH SHALL present one address per cycle, 0 to 19199 in order, with internal x 0..159 and y 0..119; x wraps to 0 and y increments when x==159.
REQ-017 Address SHALL be produced by an incrementing counter, with no multiplier; the counter returns to 0 after 19199.
REQ-018 After presenting address 19199, the FSM SHALL go to DRAIN for exactly 2 cycles, then DONE for 1 cycle.
REQ-019 Output pipeline SHALL be fixed at 2 cycles: the address presented in cycle n yields oPlot=1 with the matching oX/oY and oColour=iColour in cycle n+2.
REQ-020 oPlot SHALL be high on exactly 19200 consecutive cycles per frame, with no gaps and no duplicates.
REQ-021 oFrameDone SHALL be high only in DONE; DONE goes to FETCH if pending=1, else IDLE.
REQ-022 A state change during FETCH/DRAIN/DONE SHALL NOT abort or alter the current frame; it only sets pending, and several changes collapse into one redraw using the iState latched at the next FETCH entry.
REQ-023 With latched state 7, oFrameSel=7 and oColour SHALL be forced to 3'b000 regardless of iColour; all geometry is unchanged.
REQ-024 oBusy SHALL be 1 in FETCH and DRAIN, 0 in IDLE and DONE.
REQ-025 oAddress SHALL hold its last value outside FETCH; oX/oY/oColour hold their last values when oPlot=0.

Reset
REQ-026 iResetn=0 SHALL on the next edge force IDLE, pending=1, previous-state register=iState, counters=0, and oAddress=0, oFrameSel=0, oX=0, oY=0, oColour=0, oPlot=0, oBusy=0, oFrameDone=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame immediately: no further oPlot until the post-reset redraw.
REQ-028 The first FETCH after reset release SHALL be the cycle after the first non-reset cycle, drawing the frame for the iState then present.

Verification
REQ-029 Reset release, iState=1 held, ROM model returns address[2:0] -> oPlot high 19200 cycles, first (0,0,colour 0) and last (159,119,colour 7), oFrameDone one pulse, then IDLE with oBusy=0.
REQ-030 Pixel check on that frame -> pixel at address 160 reports x=0 y=1, address 19199 reports x=159 y=119, each exactly 2 cycles after its address.
REQ-031 iState 1->2 at pixel 5000, then 2->4 at pixel 9000 -> current frame completes with oFrameSel=1, one redraw follows immediately after DONE with oFrameSel=4, no IDLE cycle between.
REQ-032 iState=7 -> full frame drawn, every oColour=0, oFrameSel=7.
REQ-033 iResetn=0 for 1 cycle at pixel 12000 -> oPlot 0 next cycle, all outputs at reset values, then a fresh frame from (0,0).
REQ-034 iState toggles 3->5 in the DONE cycle -> pending set, FETCH entered next cycle with oFrameSel=5.
